serial_subtractor: RTL

Bit-serial WIDTH-bit subtractor computing a − b − bin, LSB first. It uses one full-subtractor cell (difference and borrow) and a registered borrow. It is the inverse-arithmetic partner to the team's full-adder datapath and serves area-constrained paths where one cell is reused over WIDTH cycles. Operands are loaded with a start pulse. The result is presented in parallel with a done pulse and also streamed serially.

---
 rtl/serial_subtractor.sv | 121 ++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin subtractor, LSB first.
// One full-subtractor cell reused over WIDTH cycles.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             diff_ser,
    output logic             diff_ser_vld
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             bout_q;

    logic a0;
    logic b0;
    logic d;
    logic br_nx;
    logic last;

    // full-subtractor cell on the current LSBs and registered borrow
    always_comb begin
        a0    = sa[0];
        b0    = sb[0];
        d     = a0 ^ b0 ^ br;
        br_nx = (~a0 & b0) | (~(a0 ^ b0) & br);
        last  = (cnt == LAST);
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next-state logic; start is ignored outside IDLE
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // operand shifters, borrow, counter and held result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        br  <= bin;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= {d, res[WIDTH-1:1]};
                    br  <= br_nx;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        diff_q <= {d, res[WIDTH-1:1]};
                        bout_q <= br_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    // outputs derive only from state and registers
    always_comb begin
        busy         = (state != IDLE);
        done         = (state == DONE);
        diff_ser_vld = (state == RUN);
        diff_ser     = diff_ser_vld & d;
        diff         = diff_q;
        bout         = bout_q;
    end

endmodule
